// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Cache-side memory request/response channel; master = requester.
// Revision    : 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int MEM_ADDR_BITS = 28,
    parameter int DATA_BITS     = 128
);
    logic                     mem_req_val;
    logic                     mem_req_rdy;
    logic [MEM_ADDR_BITS-1:0] mem_req_addr;
    logic                     mem_req_rw;
    logic                     mem_req_data_valid;
    logic                     mem_req_data_ready;
    logic [DATA_BITS-1:0]     mem_req_data_bits;
    logic [DATA_BITS/8-1:0]   mem_req_data_mask;
    logic [1:0]               mem_req_data_offset;
    logic                     mem_resp_val;
    logic                     mem_resp_nack;
    logic [DATA_BITS-1:0]     mem_resp_data;

    modport master (
        output mem_req_val, mem_req_addr, mem_req_rw, mem_req_data_valid,
               mem_req_data_bits, mem_req_data_mask, mem_req_data_offset,
        input  mem_req_rdy, mem_req_data_ready, mem_resp_val, mem_resp_nack,
               mem_resp_data
    );

    modport slave (
        input  mem_req_val, mem_req_addr, mem_req_rw, mem_req_data_valid,
               mem_req_data_bits, mem_req_data_mask, mem_req_data_offset,
        output mem_req_rdy, mem_req_data_ready, mem_resp_val, mem_resp_nack,
               mem_resp_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port icache/dcache arbiter for one memory channel; grant
//               held for a whole transaction. MEM_ARB_RR_EN selects round-robin
//               tie-break, otherwise port 1 wins ties.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int MEM_ADDR_BITS = 28,
    parameter int DATA_BITS     = 128,
    parameter int REFILL_CYCLES = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.slave  c0,
    mem_arbiter_if.slave  c1,
    mem_arbiter_if.master mem
);
    localparam int                 c_CNT_W     = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(REFILL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WDATA = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_grant, w_grant_nxt;
    logic [c_CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic                 r_is_wr, w_is_wr_nxt;
`ifdef MEM_ARB_RR_EN
    logic                 r_rr_last;
`endif

    logic                     w_own_val;
    logic [MEM_ADDR_BITS-1:0] w_own_addr;
    logic                     w_own_rw;
    logic                     w_own_dv;
    logic [DATA_BITS-1:0]     w_own_bits;
    logic [DATA_BITS/8-1:0]   w_own_mask;
    logic [1:0]               w_own_offset;

    assign w_own_val    = r_grant ? c1.mem_req_val         : c0.mem_req_val;
    assign w_own_addr   = r_grant ? c1.mem_req_addr        : c0.mem_req_addr;
    assign w_own_rw     = r_grant ? c1.mem_req_rw          : c0.mem_req_rw;
    assign w_own_dv     = r_grant ? c1.mem_req_data_valid  : c0.mem_req_data_valid;
    assign w_own_bits   = r_grant ? c1.mem_req_data_bits   : c0.mem_req_data_bits;
    assign w_own_mask   = r_grant ? c1.mem_req_data_mask   : c0.mem_req_data_mask;
    assign w_own_offset = r_grant ? c1.mem_req_data_offset : c0.mem_req_data_offset;

    logic w_fwd, w_resp_phase, w_req_hs, w_wd_hs, w_pick, w_done;

    // Outputs are gated by reset so nothing leaks while the state register is stale.
    assign w_fwd        = !reset && (r_state == S_REQ || r_state == S_WDATA);
    assign w_resp_phase = !reset && (r_state == S_RESP);
    assign w_req_hs     = w_own_val && mem.mem_req_rdy;
    assign w_wd_hs      = w_own_dv && mem.mem_req_data_ready;
    assign w_done       = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

`ifdef MEM_ARB_RR_EN
    assign w_pick = (c0.mem_req_val && c1.mem_req_val) ? ~r_rr_last : c1.mem_req_val;
`else
    assign w_pick = c1.mem_req_val;
`endif

    always_comb begin
        mem.mem_req_val         = 1'b0;
        mem.mem_req_addr        = '0;
        mem.mem_req_rw          = 1'b0;
        mem.mem_req_data_valid  = 1'b0;
        mem.mem_req_data_bits   = '0;
        mem.mem_req_data_mask   = '0;
        mem.mem_req_data_offset = '0;
        c0.mem_req_rdy          = 1'b0;
        c0.mem_req_data_ready   = 1'b0;
        c0.mem_resp_val         = 1'b0;
        c0.mem_resp_nack        = 1'b0;
        c1.mem_req_rdy          = 1'b0;
        c1.mem_req_data_ready   = 1'b0;
        c1.mem_resp_val         = 1'b0;
        c1.mem_resp_nack        = 1'b0;
        c0.mem_resp_data        = reset ? '0 : mem.mem_resp_data;
        c1.mem_resp_data        = reset ? '0 : mem.mem_resp_data;
        if (w_fwd) begin
            mem.mem_req_val         = w_own_val;
            mem.mem_req_addr        = w_own_addr;
            mem.mem_req_rw          = w_own_rw;
            mem.mem_req_data_valid  = w_own_dv;
            mem.mem_req_data_bits   = w_own_bits;
            mem.mem_req_data_mask   = w_own_mask;
            mem.mem_req_data_offset = w_own_offset;
            if (r_grant) begin
                c1.mem_req_rdy        = mem.mem_req_rdy;
                c1.mem_req_data_ready = mem.mem_req_data_ready;
            end else begin
                c0.mem_req_rdy        = mem.mem_req_rdy;
                c0.mem_req_data_ready = mem.mem_req_data_ready;
            end
        end
        if (w_resp_phase) begin
            if (r_grant) begin
                c1.mem_resp_val  = mem.mem_resp_val;
                c1.mem_resp_nack = mem.mem_resp_nack;
            end else begin
                c0.mem_resp_val  = mem.mem_resp_val;
                c0.mem_resp_nack = mem.mem_resp_nack;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_beat_cnt_nxt = r_beat_cnt;
        w_is_wr_nxt    = r_is_wr;
        case (r_state)
            S_IDLE: begin
                if (c0.mem_req_val || c1.mem_req_val) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_req_hs) begin
                    w_is_wr_nxt = w_own_rw;
                    if (!w_own_rw) begin
                        w_beat_cnt_nxt = '0;
                        w_state_nxt    = S_RESP;
                    end else if (w_wd_hs) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (w_wd_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                // A nack keeps the grant so the owner's retry is served before anyone else.
                if (mem.mem_resp_nack) begin
                    w_state_nxt = S_REQ;
                end else if (mem.mem_resp_val && !r_is_wr) begin
                    w_beat_cnt_nxt = (r_beat_cnt == c_LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
                    if (r_beat_cnt == c_LAST_BEAT) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant    <= 1'b0;
            r_beat_cnt <= '0;
            r_is_wr    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_is_wr    <= w_is_wr_nxt;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_last <= 1'b1;
        end else if (w_done) begin
            r_rr_last <= r_grant;
        end
    end
`else
    logic w_unused_done;
    assign w_unused_done = w_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0
// ============================================================================
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.MEM_ADDR_BITS(28), .DATA_BITS(128)) p0();
    mem_arbiter_if #(.MEM_ADDR_BITS(28), .DATA_BITS(128)) p1();
    mem_arbiter_if #(.MEM_ADDR_BITS(28), .DATA_BITS(128)) m();

    mem_arbiter #(
        .MEM_ADDR_BITS(28),
        .DATA_BITS    (128),
        .REFILL_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .c0   (p0),
        .c1   (p1),
        .mem  (m)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Entered in the REQ cycle (settled): accept, then four beats to the owner.
    task automatic serve(input bit own, input logic [27:0] addr);
        check("req_val", m.mem_req_val, 1);
        check("req_addr", m.mem_req_addr, addr);
        check("req_rw", m.mem_req_rw, 0);
        m.mem_req_rdy = 1'b1;
        settle();
        check("own_rdy", own ? p1.mem_req_rdy : p0.mem_req_rdy, 1);
        check("other_rdy", own ? p0.mem_req_rdy : p1.mem_req_rdy, 0);
        step();
        m.mem_req_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m.mem_resp_val  = 1'b1;
            m.mem_resp_data = {96'h0, 32'hBEEF_0000 + 32'(i)};
            settle();
            check("beat_own", own ? p1.mem_resp_val : p0.mem_resp_val, 1);
            check("beat_other", own ? p0.mem_resp_val : p1.mem_resp_val, 0);
            check("beat_bcast", own ? p0.mem_resp_data : p1.mem_resp_data,
                  {96'h0, 32'hBEEF_0000 + 32'(i)});
            check("resp_no_req", m.mem_req_val, 0);
            step();
        end
        m.mem_resp_val = 1'b0;
    endtask

    // Entered in an IDLE cycle with the requesting val(s) already driven.
    task automatic do_read(input bit own, input logic [27:0] addr);
        step();
        settle();
        serve(own, addr);
    endtask

    bit rr_model;
    bit exp_own;

    initial begin
        reset = 1'b1;
        p0.mem_req_val = 0; p0.mem_req_addr = '0; p0.mem_req_rw = 0; p0.mem_req_data_valid = 0;
        p0.mem_req_data_bits = '0; p0.mem_req_data_mask = '0; p0.mem_req_data_offset = '0;
        p1.mem_req_val = 0; p1.mem_req_addr = '0; p1.mem_req_rw = 0; p1.mem_req_data_valid = 0;
        p1.mem_req_data_bits = '0; p1.mem_req_data_mask = '0; p1.mem_req_data_offset = '0;
        m.mem_req_rdy = 0; m.mem_req_data_ready = 0; m.mem_resp_val = 0; m.mem_resp_nack = 0;
        m.mem_resp_data = '0;
        rr_model = 1'b1;

        // Reset state
        step(); step(); settle();
        check("rst_req_val", m.mem_req_val, 0);
        check("rst_c0_rdy", p0.mem_req_rdy, 0);
        check("rst_c1_resp", p1.mem_resp_val, 0);
        reset = 1'b0;
        settle();
        check("post_rst_req_val", m.mem_req_val, 0);
        check("post_rst_addr", m.mem_req_addr, 0);

        // Single read on c0 with one cycle of arbitration latency
        step();
        p0.mem_req_val = 1'b1; p0.mem_req_addr = 28'h0000123;
        settle();
        check("arb_latency", m.mem_req_val, 0);
        do_read(1'b0, 28'h0000123);
        p0.mem_req_val = 1'b0;

        // Write on c1: rdy in N, data_ready in N+2, idle in N+3
        p1.mem_req_val = 1'b1; p1.mem_req_rw = 1'b1; p1.mem_req_data_valid = 1'b1;
        p1.mem_req_addr = 28'h0000456; p1.mem_req_data_mask = 16'h000F;
        p1.mem_req_data_offset = 2'd2; p1.mem_req_data_bits = 128'hA5A5_0123_4567_89AB_CDEF_0011_2233_4455;
        step(); settle();
        check("wr_val", m.mem_req_val, 1);
        check("wr_rw", m.mem_req_rw, 1);
        check("wr_mask", m.mem_req_data_mask, 16'h000F);
        check("wr_offset", m.mem_req_data_offset, 2);
        check("wr_bits", m.mem_req_data_bits, 128'hA5A5_0123_4567_89AB_CDEF_0011_2233_4455);
        check("wr_dv", m.mem_req_data_valid, 1);
        m.mem_req_rdy = 1'b1;
        settle();
        check("wr_c1_rdy", p1.mem_req_rdy, 1);
        check("wr_c1_dready", p1.mem_req_data_ready, 0);
        check("wr_c0_rdy", p0.mem_req_rdy, 0);
        step();
        m.mem_req_rdy = 1'b0; p1.mem_req_val = 1'b0;
        settle();
        check("wdata_hold", m.mem_req_data_valid, 1);
        step();
        m.mem_req_data_ready = 1'b1;
        settle();
        check("wdata_c1_dready", p1.mem_req_data_ready, 1);
        check("wdata_c0_dready", p0.mem_req_data_ready, 0);
        step();
        m.mem_req_data_ready = 1'b0;
        settle();
        check("wr_idle", m.mem_req_data_valid, 0);
        check("wr_no_resp", p1.mem_resp_val, 0);
        p1.mem_req_data_valid = 1'b0; p1.mem_req_rw = 1'b0;

        // Three back-to-back ties
        p0.mem_req_val = 1'b1; p0.mem_req_addr = 28'h00000A0;
        p1.mem_req_val = 1'b1; p1.mem_req_addr = 28'h00000B1;
        for (int k = 0; k < 3; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_own  = ~rr_model;
            rr_model = exp_own;
`else
            exp_own = 1'b1;
`endif
            do_read(exp_own, exp_own ? 28'h00000B1 : 28'h00000A0);
        end
        p0.mem_req_val = 1'b0; p1.mem_req_val = 1'b0;

        // Nack on c0 with c1 pending: retry served first
        p0.mem_req_val = 1'b1; p0.mem_req_addr = 28'h00000C0;
        step(); settle();
        check("nack_addr", m.mem_req_addr, 28'h00000C0);
        m.mem_req_rdy = 1'b1;
        step();
        m.mem_req_rdy = 1'b0;
        p1.mem_req_val = 1'b1; p1.mem_req_addr = 28'h00000D1;
        m.mem_resp_nack = 1'b1;
        settle();
        check("nack_c0", p0.mem_resp_nack, 1);
        check("nack_c1", p1.mem_resp_nack, 0);
        step();
        m.mem_resp_nack = 1'b0;
        settle();
        serve(1'b0, 28'h00000C0);
        p0.mem_req_val = 1'b0;

        // c1 granted after retry; reset after two beats
        step(); settle();
        check("c1_after_retry", m.mem_req_addr, 28'h00000D1);
        m.mem_req_rdy = 1'b1;
        step();
        m.mem_req_rdy = 1'b0; p1.mem_req_val = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m.mem_resp_val = 1'b1;
            settle();
            check("pre_rst_beat", p1.mem_resp_val, 1);
            step();
        end
        reset = 1'b1;
        settle();
        check("midrst_c1_resp", p1.mem_resp_val, 0);
        check("midrst_c0_resp", p0.mem_resp_val, 0);
        check("midrst_req_val", m.mem_req_val, 0);
        step();
        reset = 1'b0;
        settle();
        check("beat3_dropped", p1.mem_resp_val, 0);
        check("beat3_req_val", m.mem_req_val, 0);
        step();
        m.mem_resp_val = 1'b0;
        p1.mem_req_val = 1'b1; p1.mem_req_addr = 28'h00000E1;
        do_read(1'b1, 28'h00000E1);
        p1.mem_req_val = 1'b0;

        // Stray response in IDLE
        m.mem_resp_val = 1'b1;
        settle();
        check("stray_c0", p0.mem_resp_val, 0);
        check("stray_c1", p1.mem_resp_val, 0);
        step();
        m.mem_resp_val = 1'b0;
        p0.mem_req_val = 1'b1; p0.mem_req_addr = 28'h00000F0;
        settle();
        check("stray_still_idle", m.mem_req_val, 0);
        step(); settle();
        check("stray_then_req", m.mem_req_val, 1);
        check("stray_then_addr", m.mem_req_addr, 28'h00000F0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
